// File: rtl/dmem_wait_responder.sv
// rtl/dmem_wait_responder.sv - word data memory responder with wait states, stall and error flag
module dmem_wait_responder #(
  parameter int ADDR_W      = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        err,
  output logic        stall
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [31:0]       adr_q;
  logic [31:0]       data_q;

  logic [31:0]       mem [2**ADDR_W];

  logic              commit;
  logic              acc_we;
  logic [31:0]       acc_adr;
  logic [31:0]       acc_data;
  logic              valid;
  logic [ADDR_W-1:0] idx;

  // Commit edge: last WAIT cycle, or the accept itself when there are no wait states.
  // In the zero-wait case the access has not been latched yet, so use the live inputs.
  always_comb begin
    commit   = 1'b0;
    acc_we   = we_q;
    acc_adr  = adr_q;
    acc_data = data_q;
    if (state == S_IDLE) begin
      acc_we   = we;
      acc_adr  = adr;
      acc_data = data_in;
      commit   = req && (WAIT_INIT == 4'd0);
    end else if (state == S_WAIT) begin
      commit   = (cnt == 4'd1);
    end
    valid = (acc_adr[1:0] == 2'b00) && (acc_adr[31:ADDR_W+2] == '0);
    idx   = acc_adr[ADDR_W+1:2];
  end

  // Pipeline freeze while a request is being accepted or waited on; released in RESP.
  always_comb begin
    stall = ((state == S_IDLE) && req) || (state == S_WAIT);
  end

  // Array write on the commit edge; a reset on that edge discards the store.
  always_ff @(posedge clk) begin
    if (rst_n && commit && valid && acc_we) begin
      mem[idx] <= acc_data;
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      ready    <= 1'b0;
      err      <= 1'b0;
      data_out <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            we_q   <= we;
            adr_q  <= adr;
            data_q <= data_in;
            cnt    <= WAIT_INIT;
            state  <= (WAIT_INIT == 4'd0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          ready <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // Response data and status land together with the move into RESP.
      if (commit) begin
        ready <= 1'b1;
        if (!valid) begin
          err      <= 1'b1;
          data_out <= 32'd0;
        end else if (!acc_we) begin
          data_out <= mem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// tb/tb_dmem_wait_responder.sv - directed self-checking bench for dmem_wait_responder
module tb_dmem_wait_responder;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [31:0] adr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ready;
  logic        err;
  logic        stall;

  logic        req0;
  logic        we0;
  logic [31:0] adr0;
  logic [31:0] din0;
  logic [31:0] dout0;
  logic        ready0;
  logic        err0;
  logic        stall0;

  int n_cmp;
  int n_bad;

  dmem_wait_responder #(.ADDR_W(6), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .adr(adr), .data_in(data_in),
    .data_out(data_out), .ready(ready), .err(err), .stall(stall)
  );

  dmem_wait_responder #(.ADDR_W(6), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .adr(adr0), .data_in(din0),
    .data_out(dout0), .ready(ready0), .err(err0), .stall(stall0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one access at posedge+1 and wait (bounded) for ready; returns one cycle after RESP.
  task automatic dm_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input bit scramble, output logic [31:0] q, output logic e,
                           output int lat);
    req = 1'b1; we = w; adr = a; data_in = d; lat = 0;
    do begin
      @(posedge clk); #1;
      req = 1'b0;
      if (scramble) begin
        adr = a + 32'd4; data_in = ~d; we = ~w;
      end
      lat++;
    end while (!ready && lat < 10);
    q = data_out;
    e = err;
    @(posedge clk); #1;
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [31:0] exp_q,
                         input logic exp_e);
    logic [31:0] q; logic e; int lat;
    dm_access(1'b0, a, 32'd0, 1'b0, q, e, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_e});
    chk({tag, "_data"}, q, exp_q);
  endtask

  task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic exp_e, input logic [31:0] exp_q);
    logic [31:0] q; logic e; int lat;
    dm_access(1'b1, a, d, 1'b0, q, e, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_e});
    chk({tag, "_dout"}, q, exp_q);
  endtask

  initial begin
    logic [31:0] q;
    logic        e;
    int          lat;
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; adr = '0; data_in = '0;
    req0 = 1'b0; we0 = 1'b0; adr0 = '0; din0 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dout", data_out, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_ready0", {31'd0, ready0}, 32'd0);

    // Store 0xDEADBEEF to 0x10, cycle by cycle
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; adr = 32'h10; data_in = 32'hDEADBEEF;
    #1 chk("st_stall_acc", {31'd0, stall}, 32'd1);
    @(posedge clk); #1; req = 1'b0;
    chk("st_stall_w1", {31'd0, stall}, 32'd1);
    chk("st_ready_w1", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    chk("st_stall_w2", {31'd0, stall}, 32'd1);
    chk("st_ready_w2", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    chk("st_ready", {31'd0, ready}, 32'd1);
    chk("st_err", {31'd0, err}, 32'd0);
    chk("st_stall_resp", {31'd0, stall}, 32'd0);
    chk("st_dout", data_out, 32'd0);
    @(posedge clk); #1;
    chk("st_ready_clr", {31'd0, ready}, 32'd0);

    do_load("ld10", 32'h10, 32'hDEADBEEF, 1'b0);
    do_store("st00", 32'h00, 32'h0BADF00D, 1'b0, 32'hDEADBEEF);
    do_store("st04", 32'h04, 32'h11112222, 1'b0, 32'hDEADBEEF);

    // Misaligned load
    do_load("mis06", 32'h06, 32'h0, 1'b1);
    do_load("ld04", 32'h04, 32'h11112222, 1'b0);

    // Out-of-range store; word 0 would alias if the upper bits were ignored
    do_store("oor100", 32'h100, 32'h12345678, 1'b1, 32'h0);
    do_load("ld00", 32'h00, 32'h0BADF00D, 1'b0);
    do_load("ld10b", 32'h10, 32'hDEADBEEF, 1'b0);
    do_load("ld04b", 32'h04, 32'h11112222, 1'b0);

    // Reset in the 2nd WAIT cycle of a store to 0x20
    do_store("st20", 32'h20, 32'h5A5A0000, 1'b0, 32'h11112222);
    req = 1'b1; we = 1'b1; adr = 32'h20; data_in = 32'hAAAA5555;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    chk("ab_ready", {31'd0, ready}, 32'd0);
    chk("ab_stall", {31'd0, stall}, 32'd0);
    chk("ab_err", {31'd0, err}, 32'd0);
    chk("ab_dout", data_out, 32'd0);
    @(posedge clk); #1;
    chk("ab_ready2", {31'd0, ready}, 32'd0);
    do_load("ld20", 32'h20, 32'h5A5A0000, 1'b0);

    // Inputs changed during WAIT are ignored
    do_store("st14", 32'h14, 32'h14141414, 1'b0, 32'h5A5A0000);
    dm_access(1'b1, 32'h10, 32'hCAFE0001, 1'b1, q, e, lat);
    chk("scr_lat", 32'(lat), 32'd3);
    chk("scr_err", {31'd0, e}, 32'd0);
    do_load("scr_ld10", 32'h10, 32'hCAFE0001, 1'b0);
    do_load("scr_ld14", 32'h14, 32'h14141414, 1'b0);

    // Zero wait states, req held high across three stores then three loads
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        req0 = 1'b1; we0 = 1'b1; adr0 = 32'(i / 2) * 32'd4; din0 = 32'hA0 + 32'(i);
      end
      #1;
      chk($sformatf("z_st_stall%0d", i), {31'd0, stall0}, {31'd0, (i % 2 == 0)});
      chk($sformatf("z_st_ready%0d", i), {31'd0, ready0}, {31'd0, (i % 2 == 1)});
      if (i % 2 == 1) chk($sformatf("z_st_err%0d", i), {31'd0, err0}, 32'd0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        req0 = 1'b1; we0 = 1'b0; adr0 = 32'(i / 2) * 32'd4; din0 = 32'hFFFFFFFF;
      end
      #1;
      chk($sformatf("z_ld_stall%0d", i), {31'd0, stall0}, {31'd0, (i % 2 == 0)});
      chk($sformatf("z_ld_ready%0d", i), {31'd0, ready0}, {31'd0, (i % 2 == 1)});
      if (i % 2 == 1) chk($sformatf("z_ld_data%0d", i), dout0, 32'hA0 + 32'(i - 1));
      @(posedge clk); #1;
    end
    req0 = 1'b0;
    #1 chk("z_idle_stall", {31'd0, stall0}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
